// File: rtl/avalon_mm_copy_master.sv
// Avalon-MM copy engine: one read, one write per word, one transaction in flight.
// Define COPY_MASTER_CHECKSUM_EN to add a modulo-2^32 sum of the copied words.
module avalon_mm_copy_master #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
`ifdef COPY_MASTER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [DATA_W-1:0] r_data;

  logic w_take_start;
  logic w_rd_acc;
  logic w_rd_cap;
  logic w_wr_acc;
  logic w_last;
  logic w_unused_addr;

  // Byte-offset bits are dropped: every access is word aligned.
  assign w_unused_addr = &{1'b0, src_addr[1:0], dst_addr[1:0]};

  assign w_take_start = (r_state == IDLE) & start;
  assign w_rd_acc     = (r_state == RD_REQ) & ~avm_waitrequest;
  assign w_rd_cap     = (r_state == RD_WAIT) & avm_readdatavalid;
  assign w_wr_acc     = (r_state == WR_REQ) & ~avm_waitrequest;
  assign w_last       = (r_rem == LEN_W'(1));

  assign avm_byteenable = 4'hF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (len_words == '0) begin
            w_state_nxt = FINISH;
          end else begin
            w_state_nxt = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        avm_read    = 1'b1;
        avm_address = r_src;
        busy        = 1'b1;
        if (w_rd_acc) begin
          w_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (w_rd_cap) begin
          w_state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        avm_write     = 1'b1;
        avm_address   = r_dst;
        avm_writedata = r_data;
        busy          = 1'b1;
        if (w_wr_acc) begin
          if (w_last) begin
            w_state_nxt = FINISH;
          end else begin
            w_state_nxt = RD_REQ;
          end
        end
      end
      FINISH: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Address pointers wrap silently at the top of the address space.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
      r_data <= '0;
    end else begin
      if (w_take_start) begin
        r_src <= {src_addr[ADDR_W-1:2], 2'b00};
        r_dst <= {dst_addr[ADDR_W-1:2], 2'b00};
        r_rem <= len_words;
      end
      if (w_rd_cap) begin
        r_data <= avm_readdata;
      end
      if (w_wr_acc) begin
        r_src <= r_src + ADDR_W'(4);
        r_dst <= r_dst + ADDR_W'(4);
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

`ifdef COPY_MASTER_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (w_take_start) begin
      r_sum <= '0;
    end else if (w_rd_cap) begin
      r_sum <= r_sum + avm_readdata[31:0];
    end
  end

  assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_avalon_mm_copy_master.sv
// Randomized bench for avalon_mm_copy_master with a memory slave and a
// transaction-level copy model checked every cycle.
module tb_avalon_mm_copy_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy;
  logic        done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
`ifdef COPY_MASTER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  avalon_mm_copy_master #(
    .ADDR_W(32),
    .LEN_W (16),
    .DATA_W(32)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .len_words        (len_words),
    .busy             (busy),
    .done             (done),
`ifdef COPY_MASTER_CHECKSUM_EN
    .checksum         (checksum),
`endif
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_byteenable   (avm_byteenable),
    .avm_writedata    (avm_writedata),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest  (avm_waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk_eq(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Slave memory: untouched words hold an address hash.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Slave configuration, written by the sequencer.
  int cfg_lat = 1;
  int cfg_wpct = 0;
  bit cfg_spur = 1'b0;
  int stall_rd = 0;
  int stall_wr = 0;

  // Copy model: 0 = read owed, 1 = awaiting data, 2 = write owed.
  bit          m_active = 1'b0;
  bit          m_finish = 1'b0;
  int          m_phase = 0;
  int          m_idx = 0;
  int          m_n = 0;
  logic [31:0] m_sum = '0;
  logic [31:0] exp_ra[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];

  bit          pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] pdata = '0;

  logic [31:0] rlog[$];
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];

  bit          p_stall = 1'b0;
  logic        p_rd;
  logic        p_wr;
  logic [31:0] p_addr;
  logic [31:0] p_wd;

  always @(negedge clk) begin : cmp
    logic        w;
    logic        v;
    logic [31:0] d;
    logic [31:0] a;
    bit          was_active;
    if (!reset_n) begin
      chk_b("rst_read", avm_read, 1'b0);
      chk_b("rst_write", avm_write, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_done", done, 1'b0);
      chk_eq("rst_addr", avm_address, 32'h0);
      chk_eq("rst_wdata", avm_writedata, 32'h0);
`ifdef COPY_MASTER_CHECKSUM_EN
      chk_eq("rst_checksum", checksum, 32'h0);
`endif
      m_active = 1'b0;
      m_finish = 1'b0;
      m_phase = 0;
      m_sum = '0;
      pend = 1'b0;
      p_stall = 1'b0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
    end else begin
      chk_eq("byteenable", {28'h0, avm_byteenable}, 32'hF);
      chk_b("rd_wr_excl", avm_read & avm_write, 1'b0);
      chk_b("done", done, m_finish);
      chk_b("busy", busy, m_active && !m_finish);
      if (p_stall) begin
        chk_b("stall_read", avm_read, p_rd);
        chk_b("stall_write", avm_write, p_wr);
        chk_eq("stall_addr", avm_address, p_addr);
        if (p_wr) chk_eq("stall_wdata", avm_writedata, p_wd);
      end
      if (m_active && !m_finish) begin
        case (m_phase)
          0: begin
            chk_b("rd_req", avm_read, 1'b1);
            chk_b("rd_req_nowr", avm_write, 1'b0);
            chk_eq("rd_addr", avm_address, exp_ra[m_idx]);
          end
          1: begin
            chk_b("wait_nord", avm_read, 1'b0);
            chk_b("wait_nowr", avm_write, 1'b0);
          end
          default: begin
            chk_b("wr_req", avm_write, 1'b1);
            chk_b("wr_req_nord", avm_read, 1'b0);
            chk_eq("wr_addr", avm_address, exp_wa[m_idx]);
            chk_eq("wr_data", avm_writedata, exp_wd[m_idx]);
          end
        endcase
      end else begin
        chk_b("idle_nord", avm_read, 1'b0);
        chk_b("idle_nowr", avm_write, 1'b0);
      end
`ifdef COPY_MASTER_CHECKSUM_EN
      if (!m_active || m_finish) chk_eq("checksum", checksum, m_sum);
`endif
      if (m_active && m_phase == 0 && avm_read && stall_rd > 0) begin
        w = 1'b1;
        stall_rd--;
      end else if (m_active && m_phase == 2 && avm_write && stall_wr > 0) begin
        w = 1'b1;
        stall_wr--;
      end else begin
        w = (int'($urandom_range(0, 99)) < cfg_wpct);
      end
      v = 1'b0;
      d = $urandom;
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          v = 1'b1;
          d = pdata;
          pend = 1'b0;
        end
      end else if (cfg_spur && m_phase != 1 && ($urandom_range(0, 2) == 0)) begin
        v = 1'b1;
      end
      avm_waitrequest = w;
      avm_readdatavalid = v;
      avm_readdata = d;
      p_stall = w && (avm_read || avm_write);
      p_rd = avm_read;
      p_wr = avm_write;
      p_addr = avm_address;
      p_wd = avm_writedata;
      was_active = m_active;
      if (m_finish) begin
        m_active = 1'b0;
        m_finish = 1'b0;
      end else if (m_active) begin
        case (m_phase)
          0: if (avm_read && !w) begin
            m_phase = 1;
            pend = 1'b1;
            pcnt = cfg_lat;
            pdata = memrd(avm_address);
            rlog.push_back(avm_address);
          end
          1: if (v) m_phase = 2;
          default: if (avm_write && !w) begin
            mem[avm_address] = avm_writedata;
            wlog_a.push_back(avm_address);
            wlog_d.push_back(avm_writedata);
            m_idx++;
            if (m_idx == m_n) m_finish = 1'b1;
            else m_phase = 0;
          end
        endcase
      end
      if (!was_active && start) begin
        m_active = 1'b1;
        m_idx = 0;
        m_phase = 0;
        m_n = int'(len_words);
        m_sum = '0;
        exp_ra.delete();
        exp_wa.delete();
        exp_wd.delete();
        for (int i = 0; i < m_n; i++) begin
          a = (src_addr & 32'hFFFFFFFC) + 32'(4 * i);
          exp_ra.push_back(a);
          exp_wa.push_back((dst_addr & 32'hFFFFFFFC) + 32'(4 * i));
          exp_wd.push_back(memrd(a));
          m_sum = m_sum + memrd(a);
        end
        m_finish = (m_n == 0);
      end
    end
  end

  logic [31:0] cs_seen = '0;

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, input bit poke,
                          output int dc, output int bc);
    int k;
    bit got;
    k = 0;
    got = 1'b0;
    dc = 0;
    bc = 0;
    rlog.delete();
    wlog_a.delete();
    wlog_d.delete();
    @(posedge clk);
    #1;
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    len_words = n;
    while (!got && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
      start = poke && (k == 2);
      if (start) begin
        src_addr = $urandom;
        len_words = 16'($urandom);
      end
      if (busy) bc++;
      if (done) begin
        got = 1'b1;
        dc = k;
`ifdef COPY_MASTER_CHECKSUM_EN
        cs_seen = checksum;
`endif
      end
    end
    start = 1'b0;
    chk_b("done_seen", got, 1'b1);
  endtask

  initial begin : seq
    int dc;
    int bc;
    int k;
    logic [31:0] s;
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    mem[32'h0] = 32'h11111111;
    mem[32'h4] = 32'h22222222;
    mem[32'h8] = 32'h33333333;
    mem[32'hC] = 32'h44444444;
    run_copy(32'h0, 32'h100, 16'd4, 1'b0, dc, bc);
    chk_eq("t1_done_cycle", dc, 13);
    chk_eq("t1_busy_cycles", bc, 12);
    chk_eq("t1_nwrites", wlog_a.size(), 4);
    chk_eq("t1_wa0", wlog_a[0], 32'h100);
    chk_eq("t1_wd0", wlog_d[0], 32'h11111111);
    chk_eq("t1_wa3", wlog_a[3], 32'h10C);
    chk_eq("t1_wd3", wlog_d[3], 32'h44444444);

    run_copy(32'h40, 32'h200, 16'd0, 1'b0, dc, bc);
    chk_eq("t2_done_cycle", dc, 1);
    chk_eq("t2_busy_cycles", bc, 0);
    chk_eq("t2_reads", rlog.size(), 0);
    chk_eq("t2_writes", wlog_a.size(), 0);

    stall_rd = 3;
    stall_wr = 3;
    run_copy(32'h0, 32'h300, 16'd3, 1'b0, dc, bc);
    chk_eq("t3_done_cycle", dc, 16);
    chk_eq("t3_wd2", wlog_d[2], 32'h33333333);

    cfg_lat = 5;
    cfg_spur = 1'b1;
    run_copy(32'h0, 32'h400, 16'd4, 1'b0, dc, bc);
    chk_eq("t4_done_cycle", dc, 29);
    chk_eq("t4_wd1", wlog_d[1], 32'h22222222);
    cfg_lat = 1;
    cfg_spur = 1'b0;

    run_copy(32'hFFFFFFFC, 32'h1000, 16'd2, 1'b0, dc, bc);
    chk_eq("t5_ra0", rlog[0], 32'hFFFFFFFC);
    chk_eq("t5_ra1", rlog[1], 32'h0);
    run_copy(32'h3, 32'h2001, 16'd1, 1'b0, dc, bc);
    chk_eq("t5_unaligned_ra", rlog[0], 32'h0);
    chk_eq("t5_unaligned_wa", wlog_a[0], 32'h2000);
    chk_eq("t5_unaligned_wd", wlog_d[0], 32'h11111111);

    @(posedge clk);
    #1;
    start = 1'b1;
    src_addr = 32'h4000;
    dst_addr = 32'h5000;
    len_words = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!avm_write && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk_b("t6_write_reached", avm_write, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_b("t6_write_drop", avm_write, 1'b0);
    chk_b("t6_busy_drop", busy, 1'b0);
    chk_b("t6_done_low", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_copy(32'h10, 32'h600, 16'd2, 1'b0, dc, bc);
    chk_eq("t6_after_done_cycle", dc, 7);

    mem[32'h3000] = 32'h1;
    mem[32'h3004] = 32'h2;
    mem[32'h3008] = 32'h3;
    mem[32'h300C] = 32'hFFFFFFFF;
    run_copy(32'h3000, 32'h3100, 16'd4, 1'b0, dc, bc);
    chk_eq("t7_wd3", wlog_d[3], 32'hFFFFFFFF);
`ifdef COPY_MASTER_CHECKSUM_EN
    chk_eq("t7_checksum", cs_seen, 32'h5);
`endif

    for (int it = 0; it < 40; it++) begin
      cfg_lat = int'($urandom_range(1, 6));
      case ($urandom_range(0, 2))
        0: cfg_wpct = 0;
        1: cfg_wpct = 25;
        default: cfg_wpct = 60;
      endcase
      cfg_spur = 1'($urandom_range(0, 1));
      s = $urandom;
      run_copy(s, s + 32'h00100000 + ($urandom & 32'hFFFF),
               16'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
               dc, bc);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_mm_copy_master.md
Name: avalon_mm_copy_master

Overview:
Avalon-MM master that copies a block of 32-bit words from a source region to a destination region on the system interconnect, for example on-chip RAM to on-chip RAM or RAM to a peripheral buffer. It is the initiator counterpart to the on-chip memory slaves. A control interface starts it; it then issues one read, waits for the data, issues one write, and repeats. It keeps one transaction outstanding at a time and honours waitrequest and readdatavalid.

Parameters:
ADDR_W, 32, byte-address width of avm_address
LEN_W, 16, width of the word-count input
DATA_W, 32, data width; fixed at 32 (byteenable is always 4'hF)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a copy; sampled only in IDLE
src_addr  in  ADDR_W  source byte address; bits [1:0] ignored
dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored
len_words  in  LEN_W  number of 32-bit words to copy
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the copy completes
avm_address  out  ADDR_W  byte address, always word-aligned
avm_read  out  1  read request
avm_write  out  1  write request
avm_byteenable  out  4  constant 4'hF
avm_writedata  out  32  write data
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data strobe
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - busy, done, avm_read and avm_write are 0.
  - avm_address and avm_writedata are 0.
  - Internal counters are cleared.
  - Reset mid-transfer aborts immediately; no completion pulse follows.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE:
  - On start=1, latch src[ADDR_W-1:2]<<2, dst likewise, and len_words.
  - If len_words=0, go to FINISH; no bus activity occurs.
  - Otherwise go to RD_REQ.
  - start in any other state is ignored.
- RD_REQ:
  - Drive avm_read=1 and avm_address=cur_src.
  - Hold both stable while avm_waitrequest=1.
  - On avm_read & ~avm_waitrequest, go to RD_WAIT.
- RD_WAIT:
  - On avm_readdatavalid=1, capture avm_readdata into the data register and go to WR_REQ.
  - readdatavalid in this state may arrive in the same cycle as entry or any number of cycles later.
  - readdatavalid is ignored in all other states.
- WR_REQ:
  - Drive avm_write=1, avm_address=cur_dst and avm_writedata=the data register.
  - Hold all stable while avm_waitrequest=1.
  - On acceptance: cur_src+=4, cur_dst+=4 (both modulo 2^ADDR_W, wrap silently) and remaining-=1.
  - If remaining was 1, go to FINISH; otherwise go to RD_REQ.
- FINISH: done=1 for exactly one cycle, busy drops in the same cycle, then return to IDLE.
- avm_read and avm_write are never high in the same cycle.
- Latency with zero waitrequest and a read latency of 1:
  - 3 cycles per word.
  - N words give done at cycle 3N+1 after the start cycle.
- Overlapping source and destination regions are copied in ascending address order; the caller is responsible for forward-overlap hazards.

Optional Feature:
Macro COPY_MASTER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0].
  - Cleared to 0 on reset and when start is accepted.
  - Each captured read word is added modulo 2^32.
  - The value is stable and valid while done=1 and holds until the next start.
- When undefined: the port and the adder are absent, and behaviour is otherwise identical.

Test Plan:
- Copy 4 words from 0x0000 to 0x0100. Memory model: latency 1, no wait; source words 0x11111111..0x44444444 -> writes at 0x100,0x104,0x108,0x10C with the matching data; done at cycle 13; busy high for cycles 1-12.
- len_words=0 with start -> no avm_read or avm_write ever asserted; done pulses one cycle later.
- waitrequest held high for 3 cycles on the first read and the first write -> address, read, write and writedata stay stable during the stall; the copy still completes correctly.
- Read latency 5 with spurious readdatavalid pulses in RD_REQ -> spurious pulses ignored; data is captured only in RD_WAIT.
- src=0xFFFFFFFC, len=2 -> second read at 0x00000000 (wrap); src_addr=0x00000003 is treated as 0x00000000.
- reset_n low during WR_REQ -> avm_write, busy and done drop immediately; after release, start works normally. With COPY_MASTER_CHECKSUM_EN, words 1,2,3,0xFFFFFFFF give checksum=0x00000005.
